// File: rtl/agex_stage_pkg.sv
// Shared widths, opcode enumeration and latch layouts for the execute/address-generation stage.
package agex_stage_pkg;
  localparam int DBITS     = 32;
  localparam int MUL_STEPS = 32;
  localparam int IOPBITS   = 6;

  localparam int FROM_AGEX_TO_DE_WIDTH = 1;
  localparam int FROM_AGEX_TO_FE_WIDTH = 1 + DBITS;

  typedef enum logic [IOPBITS-1:0] {
    INVALID_I, ADD_I, SUB_I, AND_I, OR_I, XOR_I, SLT_I, SLTU_I, SLL_I, SRL_I, SRA_I,
    ADDI_I, ANDI_I, ORI_I, XORI_I, SLTI_I, SLTIU_I, SLLI_I, SRLI_I, SRAI_I,
    LUI_I, AUIPC_I, LW_I, SW_I, JAL_I, JALR_I,
    BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I,
    CSRR_I, CSRW_I, MUL_I
  } op_i_e;

  typedef struct packed {
    logic [31:0]        inst;
    logic [DBITS-1:0]   pc;
    logic [DBITS-1:0]   pcplus;
    logic [IOPBITS-1:0] op_i;
    logic [31:0]        inst_count;
    logic [DBITS-1:0]   rs1_val;
    logic [DBITS-1:0]   rs2_val;
    logic [4:0]         rd;
    logic [DBITS-1:0]   sxt_imm;
    logic [31:0]        bus_canary;
  } de_latch_t;

  typedef struct packed {
    logic [31:0]        inst;
    logic [DBITS-1:0]   pc;
    logic [IOPBITS-1:0] op_i;
    logic [31:0]        inst_count;
    logic [DBITS-1:0]   result;
    logic [DBITS-1:0]   st_data;
    logic [4:0]         rd;
    logic               wr_reg;
    logic [31:0]        bus_canary;
  } agex_latch_t;

  localparam int DE_LATCH_WIDTH   = $bits(de_latch_t);
  localparam int AGEX_LATCH_WIDTH = $bits(agex_latch_t);

  // Ops whose operand B (and shift amount) comes from sxt_imm rather than rs2.
  function automatic logic uses_imm(op_i_e op);
    return op inside {ADDI_I, ANDI_I, ORI_I, XORI_I, SLTI_I, SLTIU_I, SLLI_I, SRLI_I,
                      SRAI_I, LW_I, SW_I, JALR_I};
  endfunction
endpackage

// File: rtl/agex_mul_iter.sv
// Radix-2 shift-add multiplier; one partial product per cycle, low word of the product.
module agex_mul_iter
  import agex_stage_pkg::*;
#(
  parameter int W     = DBITS,
  parameter int STEPS = MUL_STEPS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);
  localparam int CW = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_next;

  always_comb begin
    acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy    = (state_q == S_BUSY);
  assign done    = busy && (cnt_q == LAST);
  // Final step's accumulation goes straight to the latch, saving a cycle.
  assign product = acc_next;
endmodule

// File: rtl/agex_stage.sv
// Execute/address-generation stage: ALU, branch resolution, redirect to fetch, iterative MUL.
module agex_stage
  import agex_stage_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DE_LATCH_WIDTH-1:0]        from_DE_latch,
  output logic [FROM_AGEX_TO_DE_WIDTH-1:0] from_AGEX_to_DE,
  output logic [FROM_AGEX_TO_FE_WIDTH-1:0] from_AGEX_to_FE,
  output logic [AGEX_LATCH_WIDTH-1:0]      AGEX_latch_out
);
  de_latch_t   de;
  op_i_e       op;
  logic        valid, is_mul, known, taken, redirect;
  logic [DBITS-1:0] opb, sum, alu_result, target;
  logic [4:0]  shamt;
  logic        alu_wr;
  agex_latch_t alu_word, mul_word;
  agex_latch_t latch_q, latch_d;
  agex_latch_t hold_q, hold_d;
  logic        mul_start, mul_busy, mul_done;
  logic [DBITS-1:0] mul_product;

  assign de     = from_DE_latch;
  assign op     = op_i_e'(de.op_i);
  assign valid  = (de.inst != 32'd0);
  assign is_mul = valid && (op == MUL_I);

  always_comb begin
    opb        = uses_imm(op) ? de.sxt_imm : de.rs2_val;
    shamt      = uses_imm(op) ? de.sxt_imm[4:0] : de.rs2_val[4:0];
    sum        = de.rs1_val + opb;
    target     = de.pc + de.sxt_imm;
    alu_result = '0;
    alu_wr     = 1'b0;
    taken      = 1'b0;
    known      = 1'b1;
    case (op)
      ADD_I, ADDI_I:   begin alu_result = sum;                     alu_wr = 1'b1; end
      SUB_I:           begin alu_result = de.rs1_val - de.rs2_val; alu_wr = 1'b1; end
      AND_I, ANDI_I:   begin alu_result = de.rs1_val & opb;        alu_wr = 1'b1; end
      OR_I, ORI_I:     begin alu_result = de.rs1_val | opb;        alu_wr = 1'b1; end
      XOR_I, XORI_I:   begin alu_result = de.rs1_val ^ opb;        alu_wr = 1'b1; end
      SLT_I, SLTI_I: begin
        alu_result = {{(DBITS-1){1'b0}}, $signed(de.rs1_val) < $signed(opb)};
        alu_wr     = 1'b1;
      end
      SLTU_I, SLTIU_I: begin
        alu_result = {{(DBITS-1){1'b0}}, de.rs1_val < opb};
        alu_wr     = 1'b1;
      end
      SLL_I, SLLI_I:   begin alu_result = de.rs1_val << shamt;     alu_wr = 1'b1; end
      SRL_I, SRLI_I:   begin alu_result = de.rs1_val >> shamt;     alu_wr = 1'b1; end
      SRA_I, SRAI_I:   begin alu_result = $signed(de.rs1_val) >>> shamt; alu_wr = 1'b1; end
      LUI_I:           begin alu_result = de.sxt_imm;              alu_wr = 1'b1; end
      AUIPC_I:         begin alu_result = target;                  alu_wr = 1'b1; end
      LW_I:            begin alu_result = sum;                     alu_wr = 1'b1; end
      SW_I:            alu_result = sum;
      JAL_I:           begin alu_result = de.pcplus; alu_wr = 1'b1; taken = 1'b1; end
      JALR_I: begin
        alu_result = de.pcplus;
        alu_wr     = 1'b1;
        taken      = 1'b1;
        target     = {sum[DBITS-1:1], 1'b0};
      end
      BEQ_I:  taken = (de.rs1_val == de.rs2_val);
      BNE_I:  taken = (de.rs1_val != de.rs2_val);
      BLT_I:  taken = ($signed(de.rs1_val) < $signed(de.rs2_val));
      BGE_I:  taken = ($signed(de.rs1_val) >= $signed(de.rs2_val));
      BLTU_I: taken = (de.rs1_val < de.rs2_val);
      BGEU_I: taken = (de.rs1_val >= de.rs2_val);
      CSRR_I: begin alu_result = de.rs1_val; alu_wr = 1'b1; end
      CSRW_I: alu_result = de.rs1_val;
      MUL_I:  alu_wr = 1'b1;
      default: known = 1'b0;
    endcase
  end

  always_comb begin
    alu_word            = '0;
    alu_word.inst       = de.inst;
    alu_word.pc         = de.pc;
    alu_word.op_i       = de.op_i;
    alu_word.inst_count = de.inst_count;
    alu_word.result     = alu_result;
    alu_word.st_data    = de.rs2_val;
    alu_word.rd         = de.rd;
    alu_word.wr_reg     = alu_wr && (de.rd != 5'd0);
    alu_word.bus_canary = de.bus_canary;
  end

  assign mul_start = is_mul && !mul_busy;

  agex_mul_iter #(.W(DBITS), .STEPS(MUL_STEPS)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (de.rs1_val),
    .b       (de.rs2_val),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // MUL's latch fields are parked here until the product is ready.
  always_comb begin
    hold_d          = mul_start ? alu_word : hold_q;
    mul_word        = hold_q;
    mul_word.result = mul_product;
    if (mul_busy)
      latch_d = mul_done ? mul_word : '0;
    else if (!valid || !known || is_mul)
      latch_d = '0;
    else
      latch_d = alu_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_q <= '0;
      hold_q  <= '0;
    end else begin
      latch_q <= latch_d;
      hold_q  <= hold_d;
    end
  end

  assign redirect        = !reset && valid && known && taken && !mul_busy;
  assign from_AGEX_to_FE = redirect ? {1'b1, target} : '0;
  assign from_AGEX_to_DE = !reset && (is_mul || mul_busy);
  assign AGEX_latch_out  = latch_q;
endmodule

// File: tb/tb_agex_stage.sv
// Directed bench for agex_stage: ALU, branches/jumps, bubbles, iterative MUL and reset abort.
module tb_agex_stage;
  import agex_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [DE_LATCH_WIDTH-1:0]        from_DE_latch;
  logic [FROM_AGEX_TO_DE_WIDTH-1:0] from_AGEX_to_DE;
  logic [FROM_AGEX_TO_FE_WIDTH-1:0] from_AGEX_to_FE;
  logic [AGEX_LATCH_WIDTH-1:0]      AGEX_latch_out;
  agex_latch_t lo;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] INST   = 32'h0000_0033;
  localparam logic [31:0] CANARY = 32'hCAFE_0001;

  agex_stage dut (
    .clk             (clk),
    .reset           (reset),
    .from_DE_latch   (from_DE_latch),
    .from_AGEX_to_DE (from_AGEX_to_DE),
    .from_AGEX_to_FE (from_AGEX_to_FE),
    .AGEX_latch_out  (AGEX_latch_out)
  );

  assign lo = AGEX_latch_out;
  always #5 clk = ~clk;

  typedef struct {
    op_i_e       op;
    logic [31:0] rs1, rs2, imm;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic        wr;
  } alu_vec_t;

  typedef struct {
    op_i_e       op;
    logic [31:0] rs1, rs2;
    logic        taken;
  } br_vec_t;

  function automatic de_latch_t mk(op_i_e op, logic [31:0] pc, logic [31:0] pcplus,
                                   logic [31:0] rs1, logic [31:0] rs2, logic [31:0] imm,
                                   logic [4:0] rd);
    de_latch_t w;
    w            = '0;
    w.inst       = INST;
    w.pc         = pc;
    w.pcplus     = pcplus;
    w.op_i       = op;
    w.inst_count = 32'h55;
    w.rs1_val    = rs1;
    w.rs2_val    = rs2;
    w.rd         = rd;
    w.sxt_imm    = imm;
    w.bus_canary = CANARY;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(de_latch_t w);
    from_DE_latch = w;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(mk(ADD_I, 32'h0, 32'h4, 32'd1, 32'd1, 32'd0, 5'd1));
    tick();
    tick();
    vectors++;
    if (AGEX_latch_out !== '0) begin
      miscompares++;
      $display("FAIL reset_latch: got %h want 0", AGEX_latch_out);
    end
    reset = 1'b0;
    apply('0);
    vectors++;
    if (from_AGEX_to_DE !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall: got %b want 0", from_AGEX_to_DE);
    end
    vectors++;
    if (from_AGEX_to_FE !== '0) begin
      miscompares++;
      $display("FAIL reset_redirect: got %h want 0", from_AGEX_to_FE);
    end
  endtask

  task automatic test_alu();
    alu_vec_t v [20];
    v[0]  = '{ADD_I,   32'd5,         32'hFFFFFFFF, 32'd0,         5'd3,  32'd4,         1'b1};
    v[1]  = '{SUB_I,   32'd3,         32'd5,        32'd0,         5'd4,  32'hFFFFFFFE,  1'b1};
    v[2]  = '{AND_I,   32'hF0F0,      32'hFF00,     32'd0,         5'd5,  32'hF000,      1'b1};
    v[3]  = '{ORI_I,   32'h0F00,      32'h1,        32'h00F0,      5'd6,  32'h0FF0,      1'b1};
    v[4]  = '{XORI_I,  32'hFFFF0000,  32'h0,        32'hFFFFFFFF,  5'd7,  32'h0000FFFF,  1'b1};
    v[5]  = '{SLT_I,   32'd1,         32'hFFFFFFFF, 32'd0,         5'd8,  32'd0,         1'b1};
    v[6]  = '{SLTU_I,  32'd1,         32'hFFFFFFFF, 32'd0,         5'd9,  32'd1,         1'b1};
    v[7]  = '{SLTI_I,  32'hFFFFFFFF,  32'd0,        32'd1,         5'd10, 32'd1,         1'b1};
    v[8]  = '{SRA_I,   32'h80000000,  32'h24,       32'd0,         5'd11, 32'hF8000000,  1'b1};
    v[9]  = '{SRL_I,   32'h80000000,  32'h24,       32'd0,         5'd12, 32'h08000000,  1'b1};
    v[10] = '{SLL_I,   32'd1,         32'h21,       32'd0,         5'd13, 32'd2,         1'b1};
    v[11] = '{SRAI_I,  32'h80000000,  32'h1F,       32'd4,         5'd14, 32'hF8000000,  1'b1};
    v[12] = '{SLLI_I,  32'd3,         32'd0,        32'h10,        5'd15, 32'h00030000,  1'b1};
    v[13] = '{LUI_I,   32'd9,         32'd0,        32'h12345000,  5'd16, 32'h12345000,  1'b1};
    v[14] = '{AUIPC_I, 32'd9,         32'd0,        32'h1000,      5'd17, 32'h1100,      1'b1};
    v[15] = '{LW_I,    32'h1000,      32'd0,        32'hFFFFFFFC,  5'd18, 32'h0FFC,      1'b1};
    v[16] = '{SW_I,    32'h2000,      32'hAB,       32'd8,         5'd19, 32'h2008,      1'b0};
    v[17] = '{ADDI_I,  32'd1,         32'd0,        32'd1,         5'd0,  32'd2,         1'b0};
    v[18] = '{CSRR_I,  32'h77,        32'd0,        32'd0,         5'd20, 32'h77,        1'b1};
    v[19] = '{CSRW_I,  32'h88,        32'd0,        32'd0,         5'd21, 32'h88,        1'b0};
    for (int i = 0; i < 20; i++) begin
      apply(mk(v[i].op, 32'h100, 32'h104, v[i].rs1, v[i].rs2, v[i].imm, v[i].rd));
      vectors++;
      if (from_AGEX_to_DE !== 1'b0 || from_AGEX_to_FE !== '0) begin
        miscompares++;
        $display("FAIL alu_ctrl[%0d]: got stall=%b fe=%h want 0/0", i, from_AGEX_to_DE, from_AGEX_to_FE);
      end
      tick();
      vectors++;
      if (lo.result !== v[i].exp) begin
        miscompares++;
        $display("FAIL alu_result[%0d]: got %h want %h", i, lo.result, v[i].exp);
      end
      vectors++;
      if (lo.wr_reg !== v[i].wr || lo.rd !== v[i].rd) begin
        miscompares++;
        $display("FAIL alu_wr[%0d]: got wr=%b rd=%0d want wr=%b rd=%0d", i, lo.wr_reg, lo.rd, v[i].wr, v[i].rd);
      end
      vectors++;
      if (lo.st_data !== v[i].rs2 || lo.bus_canary !== CANARY || lo.pc !== 32'h100 || lo.inst !== INST) begin
        miscompares++;
        $display("FAIL alu_fields[%0d]: got st=%h can=%h pc=%h want st=%h can=%h pc=100",
                 i, lo.st_data, lo.bus_canary, lo.pc, v[i].rs2, CANARY);
      end
    end
  endtask

  task automatic test_branch();
    br_vec_t b [8];
    logic [32:0] exp_fe;
    b[0] = '{BEQ_I,  32'd9,        32'd9,        1'b1};
    b[1] = '{BEQ_I,  32'd9,        32'd8,        1'b0};
    b[2] = '{BNE_I,  32'd9,        32'd8,        1'b1};
    b[3] = '{BLT_I,  32'hFFFFFFFF, 32'd1,        1'b1};
    b[4] = '{BLTU_I, 32'hFFFFFFFF, 32'd1,        1'b0};
    b[5] = '{BGE_I,  32'd5,        32'd5,        1'b1};
    b[6] = '{BGEU_I, 32'd1,        32'hFFFFFFFF, 1'b0};
    b[7] = '{BGE_I,  32'hFFFFFFFF, 32'd0,        1'b0};
    for (int i = 0; i < 8; i++) begin
      apply(mk(b[i].op, 32'h100, 32'h104, b[i].rs1, b[i].rs2, 32'h20, 5'd1));
      exp_fe = b[i].taken ? {1'b1, 32'h120} : 33'd0;
      vectors++;
      if (from_AGEX_to_FE !== exp_fe) begin
        miscompares++;
        $display("FAIL branch_fe[%0d]: got %h want %h", i, from_AGEX_to_FE, exp_fe);
      end
      tick();
      vectors++;
      if (lo.wr_reg !== 1'b0) begin
        miscompares++;
        $display("FAIL branch_wr[%0d]: got %b want 0", i, lo.wr_reg);
      end
    end
    apply('0);
    tick();
    vectors++;
    if (from_AGEX_to_FE !== '0) begin
      miscompares++;
      $display("FAIL redirect_one_cycle: got %h want 0", from_AGEX_to_FE);
    end
  endtask

  task automatic test_jump();
    apply(mk(JALR_I, 32'h40, 32'h44, 32'h203, 32'd0, 32'd4, 5'd1));
    vectors++;
    if (from_AGEX_to_FE !== {1'b1, 32'h206}) begin
      miscompares++;
      $display("FAIL jalr_fe: got %h want 1_00000206", from_AGEX_to_FE);
    end
    tick();
    vectors++;
    if (lo.result !== 32'h44 || lo.wr_reg !== 1'b1) begin
      miscompares++;
      $display("FAIL jalr_link: got %h wr=%b want 44 wr=1", lo.result, lo.wr_reg);
    end
    apply(mk(JAL_I, 32'h100, 32'h104, 32'd0, 32'd0, 32'hFFFFFFF8, 5'd0));
    vectors++;
    if (from_AGEX_to_FE !== {1'b1, 32'hF8}) begin
      miscompares++;
      $display("FAIL jal_fe: got %h want 1_000000f8", from_AGEX_to_FE);
    end
    tick();
    vectors++;
    if (lo.result !== 32'h104 || lo.wr_reg !== 1'b0) begin
      miscompares++;
      $display("FAIL jal_link: got %h wr=%b want 104 wr=0", lo.result, lo.wr_reg);
    end
  endtask

  task automatic test_bubble();
    de_latch_t w;
    w      = mk(BEQ_I, 32'h100, 32'h104, 32'd3, 32'd3, 32'h20, 5'd2);
    w.inst = 32'd0;
    apply(w);
    vectors++;
    if (from_AGEX_to_FE !== '0 || from_AGEX_to_DE !== 1'b0) begin
      miscompares++;
      $display("FAIL bubble_ctrl: got fe=%h stall=%b want 0/0", from_AGEX_to_FE, from_AGEX_to_DE);
    end
    tick();
    vectors++;
    if (AGEX_latch_out !== '0) begin
      miscompares++;
      $display("FAIL bubble_latch: got %h want 0", AGEX_latch_out);
    end
    apply(mk(INVALID_I, 32'h100, 32'h104, 32'd3, 32'd3, 32'h20, 5'd2));
    tick();
    vectors++;
    if (lo.wr_reg !== 1'b0) begin
      miscompares++;
      $display("FAIL invalid_wr: got %b want 0", lo.wr_reg);
    end
  endtask

  task automatic run_mul(logic [31:0] a, logic [31:0] b, logic [31:0] exp,
                         de_latch_t next_w, logic exp_stall_next);
    apply(mk(MUL_I, 32'h200, 32'h204, a, b, 32'd0, 5'd7));
    vectors++;
    if (from_AGEX_to_DE !== 1'b1) begin
      miscompares++;
      $display("FAIL mul_stall_start: got %b want 1", from_AGEX_to_DE);
    end
    for (int k = 1; k <= MUL_STEPS; k++) begin
      tick();
      apply(mk(BEQ_I, 32'h100, 32'h104, 32'd5, 32'd5, 32'h40, 5'd0));
      vectors++;
      if (from_AGEX_to_DE !== 1'b1 || from_AGEX_to_FE !== '0 || AGEX_latch_out !== '0) begin
        miscompares++;
        $display("FAIL mul_busy[t+%0d]: got stall=%b fe=%h latch_res=%h want 1/0/0",
                 k, from_AGEX_to_DE, from_AGEX_to_FE, lo.result);
      end
    end
    tick();
    apply(next_w);
    vectors++;
    if (lo.result !== exp) begin
      miscompares++;
      $display("FAIL mul_product: got %h want %h", lo.result, exp);
    end
    vectors++;
    if (lo.wr_reg !== 1'b1 || lo.rd !== 5'd7 || lo.pc !== 32'h200 || lo.st_data !== b) begin
      miscompares++;
      $display("FAIL mul_fields: got wr=%b rd=%0d pc=%h st=%h want 1/7/200/%h",
               lo.wr_reg, lo.rd, lo.pc, lo.st_data, b);
    end
    vectors++;
    if (from_AGEX_to_DE !== exp_stall_next) begin
      miscompares++;
      $display("FAIL mul_stall_end: got %b want %b", from_AGEX_to_DE, exp_stall_next);
    end
  endtask

  task automatic test_back_to_back();
    run_mul(32'd7, 32'd6, 32'd42,
            mk(MUL_I, 32'h200, 32'h204, 32'hFFFFFFFF, 32'd2, 32'd0, 5'd7), 1'b1);
    run_mul(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, de_latch_t'('0), 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_mul();
    apply(mk(MUL_I, 32'h200, 32'h204, 32'd7, 32'd6, 32'd0, 5'd7));
    for (int k = 0; k < 11; k++) begin
      tick();
      apply('0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    apply('0);
    vectors++;
    if (from_AGEX_to_DE !== 1'b0 || AGEX_latch_out !== '0) begin
      miscompares++;
      $display("FAIL reset_abort: got stall=%b latch=%h want 0/0", from_AGEX_to_DE, AGEX_latch_out);
    end
    apply(mk(ADD_I, 32'h300, 32'h304, 32'd2, 32'd3, 32'd0, 5'd1));
    vectors++;
    if (from_AGEX_to_DE !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_stall: got %b want 0", from_AGEX_to_DE);
    end
    tick();
    vectors++;
    if (lo.result !== 32'd5 || lo.wr_reg !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_add: got %h wr=%b want 5 wr=1", lo.result, lo.wr_reg);
    end
    apply('0);
    for (int k = 0; k < 40; k++) tick();
    vectors++;
    if (AGEX_latch_out !== '0) begin
      miscompares++;
      $display("FAIL stale_product: got %h want 0", AGEX_latch_out);
    end
  endtask

  initial begin
    reset = 1'b1;
    from_DE_latch = '0;
    test_reset();
    test_alu();
    test_branch();
    test_jump();
    test_bubble();
    test_back_to_back();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
